// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS divide sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_e;

  localparam int DIV_WIDTH = 32;

  // One restoring step per result bit.
  localparam int DIV_ITERS = DIV_WIDTH;

  // Quotient reported when the divisor is zero; the remainder reports the dividend.
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_LO = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// try subtracting the divisor, keep the difference and set a quotient bit if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Trial subtract one bit wider than the remainder so its sign bit decides restore vs keep.
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      remOut = trial[WIDTH:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end else begin
      remOut = shifted[WIDTH:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative DIV/DIVU sequencer for the execute stage. Captures operand magnitudes,
// runs WIDTH restoring steps while stalling the pipe, then presents HI/LO for one cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  input  logic             cancelE,
  output logic             stallDivE,
  output logic             readyE,
  output logic             hilo_weE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  divState_e state;
  divState_e nextState;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic             qnegReg;
  logic             rnegReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn   (remReg),
    .quoIn   (quoReg),
    .divisor (divReg),
    .remOut  (stepRem),
    .quoOut  (stepQuo)
  );

  // Operand magnitudes and sign flags; unsigned divides never count as negative.
  always_comb begin
    aNeg = signedE & aE[WIDTH-1];
    bNeg = signedE & bE[WIDTH-1];
    absA = aNeg ? -aE : aE;
    absB = bNeg ? -bE : bE;
  end

  // State register; reset drops any divide in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state plus stall/ready; cancel wins over everything and kills stall and ready.
  always_comb begin
    nextState = state;
    stallDivE = 1'b0;
    readyE    = 1'b0;
    case (state)
      IDLE: begin
        if (startE && !cancelE) begin
          stallDivE = 1'b1;
          nextState = (bE == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cancelE) begin
          nextState = IDLE;
        end else begin
          stallDivE = 1'b1;
          if (cnt == LAST_CNT) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        readyE    = !cancelE;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath: capture operands, iterate, and register the sign-corrected result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      remReg  <= '0;
      quoReg  <= '0;
      divReg  <= '0;
      qnegReg <= 1'b0;
      rnegReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startE && !cancelE) begin
            if (bE == '0) begin
              loReg <= WIDTH'(DIV_BY_ZERO_LO);
              hiReg <= aE;
            end else begin
              remReg  <= '0;
              quoReg  <= absA;
              divReg  <= absB;
              cnt     <= '0;
              qnegReg <= aNeg ^ bNeg;
              rnegReg <= aNeg;
            end
          end
        end
        BUSY: begin
          if (!cancelE) begin
            remReg <= stepRem;
            quoReg <= stepQuo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              loReg <= qnegReg ? -stepQuo : stepQuo;
              hiReg <= rnegReg ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hilo_weE = readyE;
  assign hiE      = hiReg;
  assign loE      = loReg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a cycle-level reference of the divide's externally
// visible timing and results, compared every cycle, plus literal checks per directed op.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] aE;
  logic [31:0] bE;
  logic        cancelE;
  logic        stallDivE;
  logic        readyE;
  logic        hilo_weE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int checks = 0;
  int errors = 0;

  // Reference state: whether an op is outstanding, the cycle it completes, and visible HI/LO.
  int          cyc = 0;
  bit          mdlPend = 1'b0;
  int          mdlDoneP = 0;
  logic [31:0] mdlHiNext = '0;
  logic [31:0] mdlLoNext = '0;
  logic [31:0] mdlHiOut = '0;
  logic [31:0] mdlLoOut = '0;

  div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .startE    (startE),
    .signedE   (signedE),
    .aE        (aE),
    .bE        (bE),
    .cancelE   (cancelE),
    .stallDivE (stallDivE),
    .readyE    (readyE),
    .hilo_weE  (hilo_weE),
    .hiE       (hiE),
    .loE       (loE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // MIPS divide semantics in plain arithmetic: {remainder, quotient}.
  function automatic logic [63:0] mdlDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Advance the reference at each rising edge using the inputs presented in the ending cycle.
  always @(posedge clk) begin
    if (rst) begin
      mdlPend  <= 1'b0;
      mdlHiOut <= '0;
      mdlLoOut <= '0;
    end else if (mdlPend) begin
      if (cancelE || cyc == mdlDoneP) begin
        mdlPend <= 1'b0;
      end else if (cyc == mdlDoneP - 1) begin
        mdlHiOut <= mdlHiNext;
        mdlLoOut <= mdlLoNext;
      end
    end else if (startE && !cancelE) begin
      mdlPend <= 1'b1;
      {mdlHiNext, mdlLoNext} <= mdlDiv(signedE, aE, bE);
      if (bE == 32'd0) begin
        mdlDoneP <= cyc + 1;
        {mdlHiOut, mdlLoOut} <= mdlDiv(signedE, aE, bE);
      end else begin
        mdlDoneP <= cyc + 33;
      end
    end
    cyc <= cyc + 1;
  end

  // Compare every output against the reference on each falling edge.
  always @(negedge clk) begin : cmp
    logic        expStall;
    logic        expReady;
    logic [31:0] expHi;
    logic [31:0] expLo;
    if (rst) begin
      expStall = 1'b0;
      expReady = 1'b0;
      expHi    = '0;
      expLo    = '0;
    end else begin
      expHi = mdlHiOut;
      expLo = mdlLoOut;
      if (mdlPend && cyc == mdlDoneP) begin
        expReady = !cancelE;
        expStall = 1'b0;
      end else if (mdlPend) begin
        expReady = 1'b0;
        expStall = !cancelE;
      end else begin
        expReady = 1'b0;
        expStall = startE && !cancelE;
      end
    end
    check("cyc stallDivE", 32'(stallDivE), 32'(expStall));
    check("cyc readyE", 32'(readyE), 32'(expReady));
    check("cyc hilo_weE", 32'(hilo_weE), 32'(expReady));
    check("cyc hiE", hiE, expHi);
    check("cyc loE", loE, expLo);
  end

  // Present a divide for exactly one cycle, then scramble the operand lines.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signedE = sgn;
    aE      = a;
    bE      = b;
    startE  = 1'b1;
    @(posedge clk);
    #1;
    startE  = 1'b0;
    aE      = 32'hDEAD_BEEF;
    bE      = 32'h0;
  endtask

  // Wait (bounded) for readyE and check latency and result against hand-computed values.
  task automatic checkOutput(input string name, input int expLat, input logic [31:0] expLo,
                             input logic [31:0] expHi);
    int lat;
    bit found;
    lat   = 1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (readyE) found = 1'b1;
      else lat++;
    end
    check({name, " ready seen"}, 32'(found), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(expLat));
    check({name, " lo"}, loE, expLo);
    check({name, " hi"}, hiE, expHi);
    check({name, " hilo_we"}, 32'(hilo_weE), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    startE  = 1'b0;
    signedE = 1'b0;
    aE      = '0;
    bE      = '0;
    cancelE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset readyE", 32'(readyE), 32'd0);
    check("reset stallDivE", 32'(stallDivE), 32'd0);
    check("reset hiE", hiE, 32'd0);
    check("reset loE", loE, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7);
    checkOutput("divu 100/7", 33, 32'd14, 32'd2);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div -7/2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    checkOutput("div -100/7", 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div overflow", 33, 32'h8000_0000, 32'd0);

    applyStimulus(1'b0, 32'd5, 32'd0);
    checkOutput("divu 5/0", 1, 32'hFFFF_FFFF, 32'd5);

    applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0);
    checkOutput("div -5/0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Cancel at T+10, new divide at T+12.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cancelE = 1'b1;
    #1;
    check("cancel stall", 32'(stallDivE), 32'd0);
    check("cancel ready", 32'(readyE), 32'd0);
    @(posedge clk);
    #1;
    cancelE = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd9, 32'd3);
    checkOutput("divu 9/3 after cancel", 33, 32'd3, 32'd0);

    // Asynchronous reset at T+20 of an in-flight divide.
    applyStimulus(1'b0, 32'd50, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #2;
    check("async rst stall", 32'(stallDivE), 32'd0);
    check("async rst ready", 32'(readyE), 32'd0);
    check("async rst hi", hiE, 32'd0);
    check("async rst lo", loE, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h10);
    checkOutput("divu ffffffff/16", 33, 32'h0FFF_FFFF, 32'hF);

    // Back-to-back: second start on the cycle right after DONE.
    applyStimulus(1'b0, 32'd10, 32'd3);
    checkOutput("b2b divu 10/3", 33, 32'd3, 32'd1);
    applyStimulus(1'b1, 32'd10, 32'hFFFF_FFFD);
    checkOutput("b2b div 10/-3", 33, 32'hFFFF_FFFD, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit MIPS divide sequencer for `DIV`/`DIVU` in the execute stage. It captures operands when a divide enters E and runs a 32-step restoring division. While running, it holds the pipeline through a stall request to the hazard unit. On completion it presents quotient/remainder with a one-cycle HI/LO write enable into the hilo write path, which the hazard unit forwards through `hilo_weM`/`hilo_weW`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; counter width is clog2(WIDTH).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `startE`  in  1  divide instruction valid in E
- `signedE`  in  1  1 = `DIV`, 0 = `DIVU`
- `aE`  in  WIDTH  dividend (rs value after forwarding)
- `bE`  in  WIDTH  divisor (rt value after forwarding)
- `cancelE`  in  1  annul the op in E (exception/flush); highest priority
- `stallDivE`  out  1  combinational; hazard unit ORs it into stallF/stallD/stallE
- `readyE`  out  1  result valid this cycle
- `hilo_weE`  out  1  equals `readyE`
- `hiE`  out  WIDTH  remainder
- `loE`  out  WIDTH  quotient

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `startE && !cancelE && bE!=0` -> BUSY.
  - Latch |a| and |b| (two's-complement magnitude if `signedE`), sign flags qneg = a[31]^b[31] and rneg = a[31] (both 0 when unsigned). Clear remainder; counter = 0.
- IDLE, `startE && !cancelE && bE==0` -> DONE with lo = 32'hFFFF_FFFF, hi = aE (defined value for divide-by-zero).
- BUSY, per cycle, one restoring step:
  - {rem,quo} shifted left 1.
  - trial = rem − divisor; if non-negative, rem = trial and quo[0] = 1.
  - counter++.
  - After the step with counter==WIDTH−1 -> DONE.
- DONE:
  - Outputs lo = qneg ? −quo : quo, hi = rneg ? −rem : rem.
  - readyE = hilo_weE = 1, stallDivE = 0.
  - Unconditionally -> IDLE next cycle.
- `cancelE` in any state -> IDLE next cycle. No ready/write is produced for the cancelled op. In DONE, `cancelE` suppresses `readyE`/`hilo_weE`.
- `stallDivE` = !cancelE && ((IDLE && startE) || BUSY).
- The new instruction entering E after DONE is a distinct instruction. A second back-to-back divide starts normally from IDLE.
- Signed overflow 0x8000_0000 / −1: lo = 0x8000_0000, hi = 0. This falls out of magnitude arithmetic with no special case.
- All arithmetic is modulo 2^WIDTH. The remainder register is WIDTH+1 bits for the trial subtract.

## Timing
- Start sampled at cycle T:
  - BUSY occupies T+1..T+32.
  - DONE/ready at T+33.
  - `stallDivE` is high T..T+32 (33 cycles) and low at T+33.
- Divide-by-zero: stall high at T only; ready at T+1.
- hi/lo are registered, stable throughout DONE, and hold their last value otherwise.
- Reset (async, any time) -> IDLE, counter 0, readyE = hilo_weE = stallDivE = 0, hiE = loE = 0. An op in flight is dropped.
- Reset release: the first start is accepted on the first rising edge with rst low.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, BUSY, DONE}.
  - `DIV_ITERS` = WIDTH.
  - `DIV_BY_ZERO_LO` = all-ones.
- Sub-module `div_step`: combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem, next quo.
- FSM, counter, sign fix-up and registers live in `div_seq`.

## Test plan
- DIVU 100/7 at T -> stall T..T+32; at T+33 readyE=1, lo=14, hi=2, hilo_weE=1.
- DIV −7/2 (0xFFFF_FFF9, 2) -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF at T+33.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0. DIVU 5/0 -> ready at T+1, lo=0xFFFF_FFFF, hi=5.
- cancelE at T+10 -> IDLE at T+11, stallDivE low from T+10, readyE never asserts. A new DIVU 9/3 at T+12 gives lo=3, hi=0 at T+45.
- rst pulsed at T+20 mid-divide -> all outputs 0 immediately. After release, DIVU 0xFFFF_FFFF/0x10 -> lo=0x0FFF_FFFF, hi=0xF.
- Back-to-back: DIVU 10/3 then DIV 10/−3 -> ready at T+33 (lo=3, hi=1) and T+67 (lo=0xFFFF_FFFD, hi=1).
